lsu_rmw: RTL and testbench

LSU_RMW -- requirements
Module: lsu_rmw

---
 rtl/lsu_rmw.sv | 209 ++++++++++++++++++++
 tb/tb_lsu_rmw.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_rmw.sv
`default_nettype none
// ============================================================================
// Module   : lsu_rmw
// Brief    : RV32I load/store unit. Sub-word stores use read-modify-write;
//            LSU_MISALIGN_EN enables word-crossing accesses (else misaligned = error).
// Revision : 1.0  initial release
// ============================================================================
module lsu_rmw (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_WR0  = 3'd3,
        S_WR1  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] word0_q, word0_d, word1_q, word1_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [1:0]  w_off;
    logic [2:0]  w_size;
    logic        w_cross;
    logic        w_req_err;
    logic        w_misalign;
    logic [31:0] w_addr_lo, w_addr_hi;
    logic [31:0] w_raw, w_load;
    logic [3:0]  w_bmask4;
    logic [7:0]  w_bmask8;
    logic [63:0] w_sdata64;
    logic [31:0] w_merge_lo, w_merge_hi;

    assign w_off     = addr_q[1:0];
    assign w_addr_lo = {addr_q[31:2], 2'b00};
    assign w_addr_hi = {addr_q[31:2] + 30'd1, 2'b00};

    always_comb begin
        w_size   = 3'd4;
        w_bmask4 = 4'b1111;
        case (funct3_q[1:0])
            2'b00:   begin w_size = 3'd1; w_bmask4 = 4'b0001; end
            2'b01:   begin w_size = 3'd2; w_bmask4 = 4'b0011; end
            default: begin w_size = 3'd4; w_bmask4 = 4'b1111; end
        endcase
    end

`ifdef LSU_MISALIGN_EN
    assign w_cross    = (({1'b0, w_off} + w_size) > 3'd4);
    assign w_misalign = 1'b0;
`else
    assign w_cross    = 1'b0;
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif

    // Decode of the live request, only meaningful on the acceptance edge.
    assign w_req_err = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_funct3[2] && req_we) || w_misalign;

    // Bytes arriving in this cycle feed the load result directly.
    assign word0_d = (state_q == S_RD0) ? mem_rdata : word0_q;
    assign word1_d = (state_q == S_RD1) ? mem_rdata : word1_q;
    assign w_raw   = 32'({word1_d, word0_d} >> {w_off, 3'b000});

    always_comb begin
        case (funct3_q)
            3'b000:  w_load = {{24{w_raw[7]}}, w_raw[7:0]};
            3'b001:  w_load = {{16{w_raw[15]}}, w_raw[15:0]};
            3'b100:  w_load = {24'd0, w_raw[7:0]};
            3'b101:  w_load = {16'd0, w_raw[15:0]};
            default: w_load = w_raw;
        endcase
    end

    assign w_bmask8  = {4'b0000, w_bmask4} << w_off;
    assign w_sdata64 = {32'd0, wdata_q} << {w_off, 3'b000};

    always_comb begin
        w_merge_lo = 32'd0;
        w_merge_hi = 32'd0;
        for (int i = 0; i < 4; i++) begin
            w_merge_lo[8*i +: 8] = w_bmask8[i]     ? w_sdata64[8*i +: 8]      : word0_q[8*i +: 8];
            w_merge_hi[8*i +: 8] = w_bmask8[i + 4] ? w_sdata64[32 + 8*i +: 8] : word1_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_addr   = 32'd0;
        mem_we     = 1'b0;
        mem_wdata  = 32'd0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_err) begin
                        state_d = S_DONE;
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end else if (req_we && (req_funct3 == 3'b010) && (req_addr[1:0] == 2'b00)) begin
                        state_d = S_WR0;
                    end else begin
                        state_d = S_RD0;
                    end
                end
            end
            S_RD0: begin
                mem_addr = w_addr_lo;
                if (w_cross) begin
                    state_d = S_RD1;
                end else if (we_q) begin
                    state_d = S_WR0;
                end else begin
                    state_d = S_DONE;
                    rdata_d = w_load;
                    err_d   = 1'b0;
                end
            end
            S_RD1: begin
                mem_addr = w_addr_hi;
                if (we_q) begin
                    state_d = S_WR0;
                end else begin
                    state_d = S_DONE;
                    rdata_d = w_load;
                    err_d   = 1'b0;
                end
            end
            S_WR0: begin
                mem_addr  = w_addr_lo;
                mem_we    = 1'b1;
                mem_wdata = w_merge_lo;
                state_d   = w_cross ? S_WR1 : S_DONE;
                rdata_d   = 32'd0;
                err_d     = 1'b0;
            end
            S_WR1: begin
                mem_addr  = w_addr_hi;
                mem_we    = 1'b1;
                mem_wdata = w_merge_hi;
                state_d   = S_DONE;
                rdata_d   = 32'd0;
                err_d     = 1'b0;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            word0_q  <= 32'd0;
            word1_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            word0_q <= word0_d;
            word1_q <= word1_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (req_valid && req_ready) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_rmw.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_rmw
// Brief    : Scoreboard bench for lsu_rmw against a small word memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [31:0] mem [0:15];
    logic        poke_en;
    logic [31:0] poke_a, poke_d;
    logic [31:0] pcyc = 32'd0;
    logic [31:0] we_cnt = 32'd0;
    logic [31:0] acc_cnt = 32'd0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] due;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;

    lsu_rmw dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        pcyc <= pcyc + 32'd1;
        if (poke_en) mem[poke_a[5:2]] <= poke_d;
        if (mem_we) begin
            mem[mem_addr[5:2]] <= mem_wdata;
            we_cnt <= we_cnt + 32'd1;
        end
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every response must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("resp_rdata", resp_rdata, mon_e.rdata);
                check("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
                check("resp_latency", pcyc, mon_e.due);
            end
        end
    end

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_a = a; poke_d = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
        int t;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("accept", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input int lat);
        exp_t x;
        int   t;
        present(we, f3, a, wd);
        x.rdata = er; x.err = ee; x.due = pcyc + 32'(lat);
        sbq.push_back(x);
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (sbq.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(sbq.size()), 32'd0);
        sbq.delete();
        @(negedge clk);
    endtask

    logic [31:0] w0, a0;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; poke_en = 1'b0; poke_a = 32'd0; poke_d = 32'd0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);

        poke(32'h10, 32'h8899AABB);
        poke(32'h20, 32'h11223344);
        poke(32'h28, 32'hAABBCC00);

        issue(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2);
        issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000088, 1'b0, 2);
        issue(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2);
        issue(1'b0, 3'b101, 32'h12, 32'h0, 32'h00008899, 1'b0, 2);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2);
        check("rdata_hold_idle", resp_rdata, 32'h8899AABB);

        w0 = we_cnt;
        issue(1'b1, 3'b000, 32'h21, 32'h000000EE, 32'h0, 1'b0, 3);
        check("sb_we_pulses", we_cnt - w0, 32'd1);
        check("sb_word", mem[8], 32'h1122EE44);

        issue(1'b1, 3'b001, 32'h22, 32'h00005566, 32'h0, 1'b0, 3);
        check("sh_word", mem[8], 32'h5566EE44);

        w0 = we_cnt;
        issue(1'b1, 3'b010, 32'h24, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        check("sw_we_pulses", we_cnt - w0, 32'd1);
        check("sw_word", mem[9], 32'hDEADBEEF);

        issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        w0 = we_cnt;
        issue(1'b1, 3'b100, 32'h10, 32'h12345678, 32'h0, 1'b1, 1);
        check("err_no_write_cnt", we_cnt - w0, 32'd0);
        check("err_no_write_word", mem[4], 32'h8899AABB);

        // Request held valid across a busy sb must be accepted exactly once.
        a0 = acc_cnt;
        present(1'b1, 3'b000, 32'h28, 32'h00000077);
        sbq.push_back('{rdata: 32'h0, err: 1'b0, due: pcyc + 32'd3});
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("hold_accept_once", acc_cnt - a0, 32'd1);
        check("hold_ready_idle", {31'd0, req_ready}, 32'd1);
        check("hold_sb_word", mem[10], 32'hAABBCC77);
        check("hold_drain", 32'(sbq.size()), 32'd0);
        sbq.delete();

`ifdef LSU_MISALIGN_EN
        poke(32'h0, 32'hDDCCBBAA);
        poke(32'h4, 32'h00000011);
        issue(1'b0, 3'b010, 32'h3, 32'h0, 32'h000011DD, 1'b0, 3);
        w0 = we_cnt;
        issue(1'b1, 3'b001, 32'h3, 32'h0000BEEF, 32'h0, 1'b0, 5);
        check("xsh_we_pulses", we_cnt - w0, 32'd2);
        check("xsh_word0", mem[0], 32'hEFCCBBAA);
        check("xsh_word1", mem[1], 32'h000000BE);

        poke(32'h0, 32'h12345678);
        poke(32'h4, 32'h9ABCDEF0);
        present(1'b1, 3'b010, 32'h2, 32'hCAFEF00D);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("wr1_mem_we", {31'd0, mem_we}, 32'd1);
        check("wr1_mem_addr", mem_addr, 32'h4);
        reset = 1'b1;
        #1;
        check("abort_mem_we", {31'd0, mem_we}, 32'd0);
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_word0", mem[0], 32'hF00D5678);
        check("abort_word1", mem[1], 32'h9ABCDEF0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
`else
        poke(32'h0, 32'h12345678);
        w0 = we_cnt;
        issue(1'b0, 3'b001, 32'h1, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, 3'b010, 32'h2, 32'hCAFEF00D, 32'h0, 1'b1, 1);
        check("misalign_no_write_cnt", we_cnt - w0, 32'd0);
        check("misalign_no_write_word", mem[0], 32'h12345678);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
